// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO-write bundle shared by the arbiter and whoever drives it.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_ack;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;
    logic                          ack_err;
    logic [15:0]                   word_cnt;

    // Requesters and the FIFO side.
    modport master (
        output req_valid, req_data, fifo_full, fifo_wr_ack,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, ack_err, word_cnt
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_data, fifo_full, fifo_wr_ack,
        output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, ack_err, word_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST words into a single FIFO, with write-ack checking and a word count.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant_id_r, last_owner, pick;
    logic              pick_found;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic              owner_valid;
    logic              wr_en;
    logic              wr_en_d;
    logic              ack_err_r;
    logic [15:0]       word_cnt_r;

    // Index base+k wrapped into 0..NUM_REQ-1 (k never exceeds NUM_REQ).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Word counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign owner_valid = bus.req_valid[grant_id_r];
    // A reset in progress abandons the grant immediately, so no write leaks out.
    assign wr_en = rst_n && (state == GRANT) && owner_valid && !bus.fifo_full;

    // Round-robin search: first valid requester above the previous owner.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_found && bus.req_valid[wrap_add(last_owner, k)]) begin
                pick       = wrap_add(last_owner, k);
                pick_found = 1'b1;
            end
        end
    end

    // Next-state and beat-count logic; a burst ends on its last write or when the owner runs dry.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_nxt = IDLE;
                end else if (wr_en) begin
                    beat_nxt = beat_cnt + BEAT_W'(1);
                    if (beat_cnt == BEAT_W'(MAX_BURST - 1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, beat counter and owner registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            grant_id_r <= '0;
            last_owner <= ID_W'(NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            if (state == IDLE && pick_found) begin
                grant_id_r <= pick;
                last_owner <= pick;
            end
        end
    end

    // Write-ack checking and the saturating word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_d    <= 1'b0;
            ack_err_r  <= 1'b0;
            word_cnt_r <= '0;
        end else begin
            wr_en_d <= wr_en;
            if (bus.fifo_wr_ack != wr_en_d) ack_err_r <= 1'b1;
            if (wr_en) word_cnt_r <= sat_inc16(word_cnt_r);
        end
    end

    // Only the owner sees ready, and only while the FIFO has room.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == GRANT) bus.req_ready[grant_id_r] = !bus.fifo_full;
    end

    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = (state == GRANT) ?
                              bus.req_data[int'(grant_id_r)*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    assign bus.grant_id     = grant_id_r;
    assign bus.busy         = (state == GRANT);
    assign bus.ack_err      = ack_err_r;
    assign bus.word_cnt     = word_cnt_r;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios, a cycle-level reference model
// compared on every falling edge, and literal expectations per scenario.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int MAX_BURST  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Sources: requester i offers base[i]+idx while idx < lim[i].
    logic [15:0] base    [NUM_REQ] = '{default: 16'h0};
    int          lim     [NUM_REQ] = '{default: 0};
    int          src_idx [NUM_REQ] = '{default: 0};
    logic        src_clr   = 1'b1;
    logic        full_drv  = 1'b0;
    logic        ack_force = 1'b0;
    logic        ack_q     = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = (src_idx[i] < lim[i]);
            bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = base[i] + 16'(src_idx[i]);
        end
        bus.fifo_full   = full_drv;
        bus.fifo_wr_ack = ack_q & ~ack_force;
    end

    // FIFO acknowledges each write one cycle later; sources advance on valid&ready.
    always @(posedge clk) begin
        ack_q <= bus.fifo_wr_en;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_clr) src_idx[i] <= 0;
            else if (bus.req_valid[i] && bus.req_ready[i]) src_idx[i] <= src_idx[i] + 1;
        end
    end

    // Reference model state.
    bit   model_on = 1'b0;
    bit   m_grant;
    int   m_gid, m_last, m_beats, m_wcnt;
    bit   m_wr_d, m_err;
    int   sb_cnt [NUM_REQ] = '{default: 0};
    int   cyc = 0;
    int   glog[$];
    int   wq_id[$], wq_cyc[$];
    logic [15:0] wq_dat[$];

    bit                    e_wr, found;
    logic [NUM_REQ-1:0]    e_rdy;
    logic [FIFO_WIDTH-1:0] e_dat;
    int                    cand;

    always @(negedge clk) begin
        cyc++;
        e_wr = 1'b0;
        if (model_on) begin
            e_wr  = rst_n && m_grant && bus.req_valid[m_gid] && !bus.fifo_full;
            e_rdy = '0;
            if (rst_n && m_grant && !bus.fifo_full) e_rdy[m_gid] = 1'b1;
            e_dat = m_grant ? bus.req_data[m_gid*FIFO_WIDTH +: FIFO_WIDTH] : '0;
            chk("busy",      32'(bus.busy),         32'(m_grant));
            chk("grant_id",  32'(bus.grant_id),     32'(m_gid));
            chk("req_ready", 32'(bus.req_ready),    32'(e_rdy));
            chk("wr_en",     32'(bus.fifo_wr_en),   32'(e_wr));
            chk("data_in",   32'(bus.fifo_data_in), 32'(e_dat));
            chk("ack_err",   32'(bus.ack_err),      32'(m_err));
            chk("word_cnt",  32'(bus.word_cnt),     32'(m_wcnt));
            if (e_wr) begin
                chk("order", 32'(bus.fifo_data_in), 32'(base[m_gid] + 16'(sb_cnt[m_gid])));
                sb_cnt[m_gid]++;
                wq_id.push_back(m_gid);
                wq_cyc.push_back(cyc);
                wq_dat.push_back(bus.fifo_data_in);
            end
        end
        if (src_clr) for (int i = 0; i < NUM_REQ; i++) sb_cnt[i] = 0;
        // Advance the model to what the coming rising edge must produce.
        if (!rst_n) begin
            model_on = 1'b1;
            m_grant = 1'b0; m_gid = 0; m_last = NUM_REQ - 1; m_beats = 0;
            m_wr_d = 1'b0; m_err = 1'b0; m_wcnt = 0;
        end else if (model_on) begin
            if (bus.fifo_wr_ack != m_wr_d) m_err = 1'b1;
            m_wr_d = e_wr;
            if (e_wr && m_wcnt < 65535) m_wcnt++;
            if (!m_grant) begin
                found = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = (m_last + k) % NUM_REQ;
                    if (!found && bus.req_valid[cand]) begin
                        found = 1'b1; m_gid = cand; m_last = cand;
                    end
                end
                if (found) begin
                    m_grant = 1'b1; m_beats = 0; glog.push_back(m_gid);
                end
            end else if (!bus.req_valid[m_gid]) begin
                m_grant = 1'b0;
            end else if (e_wr) begin
                m_beats++;
                if (m_beats == MAX_BURST) m_grant = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; src_clr = 1'b1; full_drv = 1'b0; ack_force = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) lim[i] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; src_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rst_busy"},  32'(bus.busy),         32'd0);
        chk({tag, "_rst_wr_en"}, 32'(bus.fifo_wr_en),   32'd0);
        chk({tag, "_rst_ready"}, 32'(bus.req_ready),    32'd0);
        chk({tag, "_rst_data"},  32'(bus.fifo_data_in), 32'd0);
        chk({tag, "_rst_gid"},   32'(bus.grant_id),     32'd0);
        chk({tag, "_rst_ackerr"},32'(bus.ack_err),      32'd0);
        chk({tag, "_rst_wcnt"},  32'(bus.word_cnt),     32'd0);
    endtask

    task automatic wait_writes(input int id, input int n, input int budget);
        int t;
        t = 0;
        while (sb_cnt[id] < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk("wait_writes", 32'(sb_cnt[id] >= n), 32'd1);
    endtask

    initial begin
        int w0, g0;

        // Single requester, two bursts of 4 and 2.
        do_reset();
        check_reset_outputs("t1");
        w0 = wq_dat.size(); g0 = glog.size();
        base[2] = 16'hA000; lim[2] = 6;
        @(posedge clk); #1;
        chk("t1_gid_after_1", 32'(bus.grant_id), 32'd2);
        chk("t1_busy_after_1", 32'(bus.busy), 32'd1);
        wait_writes(2, 6, 40);
        repeat (3) @(posedge clk); #1;
        chk("t1_word_cnt", 32'(bus.word_cnt), 32'd6);
        chk("t1_nwrites", 32'(wq_dat.size() - w0), 32'd6);
        for (int k = 0; k < 6; k++) chk("t1_data", 32'(wq_dat[w0+k]), 32'(16'hA000 + 16'(k)));
        chk("t1_burst_len", 32'(wq_cyc[w0+3] - wq_cyc[w0]), 32'd3);
        chk("t1_idle_gap",  32'(wq_cyc[w0+4] - wq_cyc[w0+3]), 32'd2);
        chk("t1_ngrants", 32'(glog.size() - g0), 32'd2);

        // Round robin with all four requesters, 8 words each.
        do_reset();
        check_reset_outputs("t2");
        w0 = wq_dat.size(); g0 = glog.size();
        for (int i = 0; i < NUM_REQ; i++) begin
            base[i] = 16'((i + 1) * 16'h1000); lim[i] = 8;
        end
        wait_writes(3, 8, 120);
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 5; k++) chk("t2_order", 32'(glog[g0+k]), 32'(k % 4));
        chk("t2_word_cnt", 32'(bus.word_cnt), 32'd32);
        chk("t2_span", 32'(wq_cyc[w0+31] - wq_cyc[w0]), 32'd38);
        chk("t2_gap", 32'(wq_cyc[w0+4] - wq_cyc[w0+3]), 32'd2);

        // FIFO full for 3 cycles after requester 1's second word.
        do_reset();
        w0 = wq_dat.size(); g0 = glog.size();
        base[1] = 16'hB000; lim[1] = 4;
        wait_writes(1, 2, 20);
        #1 full_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1 full_drv = 1'b0;
        wait_writes(1, 4, 20);
        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 4; k++) chk("t3_data", 32'(wq_dat[w0+k]), 32'(16'hB000 + 16'(k)));
        chk("t3_stall_gap", 32'(wq_cyc[w0+2] - wq_cyc[w0+1]), 32'd4);
        chk("t3_ngrants", 32'(glog.size() - g0), 32'd1);
        chk("t3_word_cnt", 32'(bus.word_cnt), 32'd4);

        // Requester 3 runs dry after 2 words; requester 0 is next.
        do_reset();
        w0 = wq_dat.size(); g0 = glog.size();
        base[3] = 16'hC000; lim[3] = 2;
        base[0] = 16'hD000; base[2] = 16'hE000;
        wait_writes(3, 2, 20);
        #1 lim[0] = 2; lim[2] = 2;
        wait_writes(2, 2, 40);
        repeat (2) @(posedge clk); #1;
        chk("t4_g0", 32'(glog[g0]),   32'd3);
        chk("t4_g1", 32'(glog[g0+1]), 32'd0);
        chk("t4_g2", 32'(glog[g0+2]), 32'd2);
        chk("t4_next_data", 32'(wq_dat[w0+2]), 32'hD000);
        chk("t4_release_gap", 32'(wq_cyc[w0+2] - wq_cyc[w0+1]), 32'd3);

        // Missing write acknowledge sets a sticky error.
        do_reset();
        base[0] = 16'h5000; lim[0] = 2;
        wait_writes(0, 1, 20);
        #1 ack_force = 1'b1;
        @(posedge clk);
        #1 ack_force = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("t5_ack_err_sticky", 32'(bus.ack_err), 32'd1);
        do_reset();
        check_reset_outputs("t5");

        // Reset during requester 2's third word; afterwards all valid -> requester 0.
        base[2] = 16'h7000; lim[2] = 100;
        for (int i = 0; i < NUM_REQ; i++) if (i != 2) base[i] = 16'((i + 8) * 16'h1000);
        wait_writes(2, 2, 20);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_outputs("t6");
        chk("t6_no_third_word", 32'(sb_cnt[2]), 32'd2);
        g0 = glog.size(); w0 = wq_dat.size();
        for (int i = 0; i < NUM_REQ; i++) lim[i] = src_idx[i] + 4;
        @(posedge clk); #1;
        chk("t6_gid", 32'(bus.grant_id), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd1);
        wait_writes(2, 3, 40);
        repeat (4) @(posedge clk); #1;
        chk("t6_first_grant", 32'(glog[g0]), 32'd0);
        chk("t6_resume_data", 32'(wq_dat[w0+8]), 32'h7002);

        repeat (20) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_REQ, 4, number of requesters (2..8).
- FIFO_WIDTH, 16, data word width.
- MAX_BURST, 4, maximum words per grant (1..16).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, synchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester word available.
- req_data, in, NUM_REQ*FIFO_WIDTH, packed request data; requester i at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready, out, NUM_REQ, per-requester word accepted this cycle when ANDed with req_valid.
- fifo_full, in, 1, FIFO full flag.
- fifo_wr_ack, in, 1, FIFO registered write acknowledge.
- fifo_wr_en, out, 1, FIFO write enable.
- fifo_data_in, out, FIFO_WIDTH, FIFO write data.
- grant_id, out, $clog2(NUM_REQ), current owner index.
- busy, out, 1, a grant is active.
- ack_err, out, 1, sticky write-acknowledge mismatch.
- word_cnt, out, 16, total words written, saturating.

Function
REQ-003 FSM SHALL have two states, IDLE and GRANT, held in a register.
REQ-004 In IDLE with any req_valid bit set, the block SHALL select the first set bit searching upward from last_owner+1 (modulo NUM_REQ), load grant_id and last_owner with it, and enter GRANT on the next edge; arbitration latency is 1 cycle.
REQ-005 In IDLE with no req_valid bit set, the FSM SHALL stay in IDLE and grant_id SHALL hold its value.
REQ-006 busy SHALL be 1 exactly when the state is GRANT.
REQ-007 In GRANT, req_ready[grant_id] SHALL be !fifo_full; all other req_ready bits SHALL be 0. In IDLE all req_ready bits SHALL be 0.
REQ-008 fifo_wr_en SHALL be combinational: state==GRANT && req_valid[grant_id] && !fifo_full.
REQ-009 fifo_data_in SHALL be req_data of grant_id while in GRANT, and 0 otherwise.
REQ-010 A beat counter SHALL clear on entry to GRANT and increment on each cycle with fifo_wr_en=1.
REQ-011 GRANT SHALL return to IDLE on the edge where:
- a write occurs and the beat count reaches MAX_BURST, or
- req_valid[grant_id] is 0.
REQ-012 While fifo_full=1 in GRANT with req_valid[grant_id]=1, the FSM SHALL remain in GRANT with no write, no beat increment and no grant change.
REQ-013 Between successive grants there SHALL be at least one IDLE cycle. A requester holding req_valid continuously SHALL wait at most (NUM_REQ-1) bursts plus their IDLE cycles.
REQ-014 The block SHALL register fifo_wr_en as wr_en_d. ack_err SHALL be set when fifo_wr_ack != wr_en_d and SHALL remain 1 until reset.
REQ-015 word_cnt SHALL increment by 1 on each fifo_wr_en=1 cycle and saturate at 16'hFFFF.
REQ-016 Data ordering within a requester SHALL be preserved. Words SHALL never be duplicated or dropped.

Reset
REQ-017 When rst_n=0 at a rising edge, the block SHALL set:
- state=IDLE
- last_owner=NUM_REQ-1
- grant_id=0
- beat counter=0
- wr_en_d=0
- ack_err=0
- word_cnt=0
REQ-018 While the state is IDLE after reset: busy=0, req_ready=0, fifo_wr_en=0, fifo_data_in=0.
REQ-019 Reset asserted mid-burst SHALL abandon the grant with no further write. After reset release, the first grant SHALL go to the lowest-indexed valid requester.

Verification
REQ-020 Single requester:
- Stimulus: reset; req_valid=4'b0100 held, data 16'hA000..A005; FIFO never full.
- Response: grant_id=2 after 1 cycle; writes A000..A003; 1 IDLE cycle; writes A004, A005; word_cnt=6.
REQ-021 Round robin:
- Stimulus: all four requesters valid continuously.
- Response: grant order 0,1,2,3,0; each grant is 4 writes; busy drops for exactly 1 cycle between bursts.
REQ-022 Full stall:
- Stimulus: requester 1 granted; fifo_full=1 for 3 cycles after its 2nd word.
- Response: fifo_wr_en=0 and req_ready=0 for those 3 cycles; grant held; words 3 and 4 written after full drops; no loss.
REQ-023 Early release:
- Stimulus: requester 3 drops req_valid after 2 words.
- Response: FSM returns to IDLE on that edge; next grant goes to requester 0 if it is valid.
REQ-024 Ack check:
- Stimulus: force fifo_wr_ack=0 one cycle after a write.
- Response: ack_err=1 and stays 1 until rst_n=0; it clears on the reset edge.
REQ-025 Reset mid-burst:
- Stimulus: rst_n=0 for 1 cycle during requester 2's 3rd word.
- Response: all outputs at reset values; no write on that edge; with req_valid=4'b1111 afterwards, the next grant goes to requester 0.
